piv_cmd_seq: RTL and testbench

- Synthesizable pivot command sequencer; replaces the hand-written load/store loops that drive acc_top during a simplex pivot.
- Given tableau dimensions, the pivot position and a runtime band width, it emits an ordered stream of memory-load, immediate-load and store commands over a valid/ready handshake.
- Result registers rotate over RES_LAG slots instead of a fixed ping-pong pair.
- The band width is fully general: any 1 ≤ w ≤ W_MAX, with w above, equal to or below N.

---
 rtl/piv_cmd_seq.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_piv_cmd_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piv_cmd_seq.sv
// Pivot command sequencer: walks a simplex tableau band by band and emits
// load/store commands for the accelerator over a valid/ready handshake.
module piv_cmd_seq #(
  parameter int W_MAX   = 8,
  parameter int RES_LAG = 2,
  parameter int DIM_W   = 16,
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [DIM_W-1:0]  m_i,
  input  logic [DIM_W-1:0]  n_i,
  input  logic [DIM_W-1:0]  p_i,
  input  logic [DIM_W-1:0]  q_i,
  input  logic [DIM_W-1:0]  w_i,
  input  logic [REG_W-1:0]  xs_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [1:0]        cmd_type_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [REG_W-1:0]  cmd_reg_o,
  output logic [31:0]       cmd_imm_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int PW = (RES_LAG > 1) ? $clog2(RES_LAG) : 1;
  localparam int CW = $clog2(RES_LAG + 1);
  localparam int XW = DIM_W + 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PIV_LOAD  = 3'd1;
  localparam logic [2:0] S_ROW_HDR   = 3'd2;
  localparam logic [2:0] S_ROW_ELEM  = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;
  localparam logic [2:0] S_PIV_STORE = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam logic [1:0] T_MEM   = 2'd0;
  localparam logic [1:0] T_IMM   = 2'd1;
  localparam logic [1:0] T_STORE = 2'd2;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_base, r_nm1, r_prow, r_rowa;
  logic [DIM_W-1:0]  r_m, r_n, r_p, r_q, r_w;
  logic [DIM_W-1:0]  r_i, r_b, r_j;
  logic [REG_W-1:0]  r_xs;
  logic [PW-1:0]     r_e, r_wp, r_rp;
  logic [CW-1:0]     r_cnt;
  logic              r_err;
  logic [ADDR_W-1:0] r_fa [RES_LAG];
  logic [REG_W-1:0]  r_fr [RES_LAG];

  logic [XW-1:0]     w_b_plus_w, w_band_end, w_j_inc, w_j_next, w_j_first;
  logic [XW-1:0]     w_i_first, w_i_inc, w_i_next;
  logic [ADDR_W-1:0] w_rowa_first, w_rowa_next, w_push_addr;
  logic [REG_W-1:0]  w_slot, w_res_reg;
  logic              w_more_rows, w_first_rows, w_last_col, w_pst_valid;
  logic              w_fifo_full, w_fire, w_push, w_pop, w_start_bad;

  function automatic logic [PW-1:0] ring_inc(input logic [PW-1:0] v);
    return (v == PW'(RES_LAG - 1)) ? '0 : v + PW'(1);
  endfunction

  // Column walk within the current band; the pivot column is skipped for
  // element work and pivot-row stores.
  assign w_b_plus_w  = XW'(r_b) + XW'(r_w);
  assign w_band_end  = (w_b_plus_w < XW'(r_n)) ? w_b_plus_w : XW'(r_n);
  assign w_j_inc     = XW'(r_j) + XW'(1);
  assign w_j_next    = (w_j_inc == XW'(r_q)) ? w_j_inc + XW'(1) : w_j_inc;
  assign w_j_first   = (r_b == r_q) ? XW'(r_b) + XW'(1) : XW'(r_b);
  assign w_pst_valid = XW'(r_j) < w_band_end;
  assign w_last_col  = (r_j == r_n - DIM_W'(1));
  assign w_slot      = REG_W'(r_j - r_b);

  // Row walk skips the pivot row; row base address advances incrementally.
  assign w_i_first    = (r_p == '0) ? XW'(1) : '0;
  assign w_i_inc      = XW'(r_i) + XW'(1);
  assign w_i_next     = (w_i_inc == XW'(r_p)) ? w_i_inc + XW'(1) : w_i_inc;
  assign w_first_rows = w_i_first < XW'(r_m);
  assign w_more_rows  = w_i_next < XW'(r_m);
  assign w_rowa_first = (r_p == '0) ? r_base + r_nm1 : r_base;
  assign w_rowa_next  = (w_i_inc == XW'(r_p)) ? r_rowa + (r_nm1 << 1) : r_rowa + r_nm1;

  assign w_fifo_full = (r_cnt == CW'(RES_LAG));
  assign w_res_reg   = r_xs + REG_W'(W_MAX) + REG_W'(r_e);
  assign w_fire      = cmd_valid_o & cmd_ready_i;
  assign w_push      = (r_state == S_ROW_ELEM) && !w_fifo_full && w_fire;
  assign w_pop       = w_fire && (((r_state == S_ROW_ELEM) && w_fifo_full) ||
                                  (r_state == S_DRAIN));
  // The implicit last column swaps into the pivot column's storage slot.
  assign w_push_addr = r_rowa + ADDR_W'(w_last_col ? r_q : r_j);

  assign w_start_bad = (m_i == '0) || (n_i < DIM_W'(2)) || (p_i >= m_i) ||
                       (q_i >= n_i - DIM_W'(1)) || (w_i == '0) ||
                       (XW'(w_i) > XW'(W_MAX));

  always_comb begin
    cmd_valid_o = 1'b0;
    cmd_type_o  = T_MEM;
    cmd_addr_o  = '0;
    cmd_reg_o   = '0;
    cmd_imm_o   = '0;
    case (r_state)
      S_PIV_LOAD: begin
        cmd_valid_o = 1'b1;
        cmd_reg_o   = r_xs + w_slot;
        if (w_last_col) begin
          cmd_type_o = T_IMM;
          cmd_imm_o  = 32'h3f80_0000;
        end else begin
          cmd_addr_o = r_prow + ADDR_W'(r_j);
        end
      end
      S_ROW_HDR: begin
        cmd_valid_o = 1'b1;
        cmd_addr_o  = r_rowa + ADDR_W'(r_q);
      end
      S_ROW_ELEM: begin
        cmd_valid_o = 1'b1;
        if (w_fifo_full) begin
          cmd_type_o = T_STORE;
          cmd_addr_o = r_fa[r_rp];
          cmd_reg_o  = r_fr[r_rp];
        end else begin
          cmd_reg_o = w_res_reg;
          if (w_last_col) cmd_type_o = T_IMM;
          else            cmd_addr_o = r_rowa + ADDR_W'(r_j);
        end
      end
      S_DRAIN: begin
        if (r_cnt != '0) begin
          cmd_valid_o = 1'b1;
          cmd_type_o  = T_STORE;
          cmd_addr_o  = r_fa[r_rp];
          cmd_reg_o   = r_fr[r_rp];
        end
      end
      S_PIV_STORE: begin
        if (w_pst_valid) begin
          cmd_valid_o = 1'b1;
          cmd_type_o  = T_STORE;
          cmd_reg_o   = r_xs + w_slot;
          cmd_addr_o  = r_prow + ADDR_W'(w_last_col ? r_q : r_j);
        end
      end
      default: ;
    endcase
  end

  assign busy_o = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_o = (r_state == S_DONE);
  assign err_o  = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < RES_LAG; k++) begin
        r_fa[k] <= '0;
        r_fr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < RES_LAG; k++) begin
        if (w_push && (r_wp == PW'(k))) begin
          r_fa[k] <= w_push_addr;
          r_fr[k] <= w_res_reg;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_nm1   <= '0;
      r_prow  <= '0;
      r_rowa  <= '0;
      r_m     <= '0;
      r_n     <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_w     <= '0;
      r_i     <= '0;
      r_b     <= '0;
      r_j     <= '0;
      r_xs    <= '0;
      r_e     <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_push) begin
        r_wp <= ring_inc(r_wp);
        r_e  <= ring_inc(r_e);
      end
      if (w_pop) r_rp <= ring_inc(r_rp);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (w_start_bad) begin
              r_err <= 1'b1;
            end else begin
              r_base  <= base_i;
              r_m     <= m_i;
              r_n     <= n_i;
              r_p     <= p_i;
              r_q     <= q_i;
              r_w     <= w_i;
              r_xs    <= xs_i;
              r_nm1   <= ADDR_W'(n_i) - ADDR_W'(1);
              r_prow  <= base_i + ADDR_W'(p_i) * (ADDR_W'(n_i) - ADDR_W'(1));
              r_b     <= '0;
              r_j     <= '0;
              r_e     <= '0;
              r_wp    <= '0;
              r_rp    <= '0;
              r_cnt   <= '0;
              r_state <= S_PIV_LOAD;
            end
          end
        end
        S_PIV_LOAD: begin
          if (w_fire) begin
            if (w_j_inc < w_band_end) begin
              r_j <= DIM_W'(w_j_inc);
            end else if (w_first_rows) begin
              r_i     <= DIM_W'(w_i_first);
              r_rowa  <= w_rowa_first;
              r_state <= S_ROW_HDR;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_ROW_HDR: begin
          if (w_fire) begin
            if (w_j_first < w_band_end) begin
              r_j     <= DIM_W'(w_j_first);
              r_state <= S_ROW_ELEM;
            end else if (w_more_rows) begin
              r_i    <= DIM_W'(w_i_next);
              r_rowa <= w_rowa_next;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_ROW_ELEM: begin
          if (w_push) begin
            if (w_j_next < w_band_end) begin
              r_j <= DIM_W'(w_j_next);
            end else if (w_more_rows) begin
              r_i     <= DIM_W'(w_i_next);
              r_rowa  <= w_rowa_next;
              r_state <= S_ROW_HDR;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (r_cnt == '0) begin
            r_j     <= DIM_W'(w_j_first);
            r_state <= S_PIV_STORE;
          end
        end
        S_PIV_STORE: begin
          if (!w_pst_valid || w_fire) begin
            if (w_pst_valid && (w_j_next < w_band_end)) begin
              r_j <= DIM_W'(w_j_next);
            end else if (w_band_end < XW'(r_n)) begin
              r_b     <= DIM_W'(w_band_end);
              r_j     <= DIM_W'(w_band_end);
              r_e     <= '0;
              r_state <= S_PIV_LOAD;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piv_cmd_seq.sv
// Scoreboard bench for piv_cmd_seq: a loop-nest reference model queues the
// expected command stream and a negedge monitor checks every transfer.
module tb_piv_cmd_seq;
  localparam int W_MAX   = 8;
  localparam int RES_LAG = 2;
  localparam logic [1:0] T_MEM   = 2'd0;
  localparam logic [1:0] T_IMM   = 2'd1;
  localparam logic [1:0] T_STORE = 2'd2;

  typedef struct packed {
    logic [1:0]  t;
    logic [31:0] a;
    logic [4:0]  r;
    logic [31:0] imm;
  } cmd_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] base_i = '0;
  logic [15:0] m_i = '0, n_i = '0, p_i = '0, q_i = '0, w_i = '0;
  logic [4:0]  xs_i = '0;
  logic        cmd_valid_o, cmd_ready_i;
  logic [1:0]  cmd_type_o;
  logic [31:0] cmd_addr_o;
  logic [4:0]  cmd_reg_o;
  logic [31:0] cmd_imm_o;
  logic        busy_o, done_o, err_o;

  piv_cmd_seq #(.W_MAX(W_MAX), .RES_LAG(RES_LAG), .DIM_W(16), .ADDR_W(32), .REG_W(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_i(base_i),
    .m_i(m_i), .n_i(n_i), .p_i(p_i), .q_i(q_i), .w_i(w_i), .xs_i(xs_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_type_o(cmd_type_o),
    .cmd_addr_o(cmd_addr_o), .cmd_reg_o(cmd_reg_o), .cmd_imm_o(cmd_imm_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  cmd_t exp_q[$];
  cmd_t cap[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   ntx = 0;
  logic bp_en = 1'b0;
  logic stalled = 1'b0;
  cmd_t held, mon_cur, mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic cmd_t mk(input logic [1:0] t, input logic [31:0] a, input int r,
                              input logic [31:0] imm);
    cmd_t c;
    c.t = t; c.a = a; c.r = 5'(r); c.imm = imm;
    return c;
  endfunction

  function automatic logic [31:0] ad(input logic [31:0] base, input int n, input int i, input int j);
    return base + 32'(i) * 32'(n - 1) + 32'(j);
  endfunction

  // Reference model: plain loop nest over bands, rows and columns with a
  // software queue standing in for the accelerator result latency.
  task automatic gen_expected(input logic [31:0] base, input int m, input int n, input int p,
                              input int q, input int w, input int xs);
    logic [31:0] fa[$];
    int fr[$];
    int e, be;
    for (int b = 0; b < n; b += w) begin
      be = (b + w < n) ? b + w : n;
      e = 0;
      for (int j = b; j < be; j++) begin
        if (j == n - 1) exp_q.push_back(mk(T_IMM, 0, xs + j - b, 32'h3f800000));
        else            exp_q.push_back(mk(T_MEM, ad(base, n, p, j), xs + j - b, 0));
      end
      for (int i = 0; i < m; i++) begin
        if (i == p) continue;
        exp_q.push_back(mk(T_MEM, ad(base, n, i, q), 0, 0));
        for (int j = b; j < be; j++) begin
          if (j == q) continue;
          if (fa.size() == RES_LAG) exp_q.push_back(mk(T_STORE, fa.pop_front(), fr.pop_front(), 0));
          if (j == n - 1) exp_q.push_back(mk(T_IMM, 0, xs + W_MAX + e, 0));
          else            exp_q.push_back(mk(T_MEM, ad(base, n, i, j), xs + W_MAX + e, 0));
          fa.push_back(ad(base, n, i, (j == n - 1) ? q : j));
          fr.push_back(xs + W_MAX + e);
          e = (e + 1) % RES_LAG;
        end
      end
      while (fa.size() > 0) exp_q.push_back(mk(T_STORE, fa.pop_front(), fr.pop_front(), 0));
      for (int j = b; j < be; j++) begin
        if (j == q) continue;
        exp_q.push_back(mk(T_STORE, ad(base, n, p, (j == n - 1) ? q : j), xs + j - b, 0));
      end
    end
  endtask

  always @(negedge clk_i) begin
    mon_cur = {cmd_type_o, cmd_addr_o, cmd_reg_o, cmd_imm_o};
    if (!rst_ni) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid_held", 32'(cmd_valid_o), 32'd1);
        check("stall_type_held", 32'(mon_cur.t), 32'(held.t));
        check("stall_addr_held", mon_cur.a, held.a);
        check("stall_reg_held", 32'(mon_cur.r), 32'(held.r));
        check("stall_imm_held", mon_cur.imm, held.imm);
      end
      if (cmd_valid_o && cmd_ready_i) begin
        $display("cmd %0d: type=%0d addr=%h reg=%0d imm=%h", ntx, mon_cur.t, mon_cur.a,
                 mon_cur.r, mon_cur.imm);
        ntx++;
        cap.push_back(mon_cur);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: actual type=%0d addr=%h, required no command",
                   mon_cur.t, mon_cur.a);
        end else begin
          mon_exp = exp_q.pop_front();
          check("cmd_type", 32'(mon_cur.t), 32'(mon_exp.t));
          check("cmd_reg", 32'(mon_cur.r), 32'(mon_exp.r));
          if (mon_exp.t == T_IMM) check("cmd_imm", mon_cur.imm, mon_exp.imm);
          else                    check("cmd_addr", mon_cur.a, mon_exp.a);
        end
      end
      stalled = cmd_valid_o && !cmd_ready_i;
      held = mon_cur;
      if (done_o) begin
        done_cnt++;
        check("busy_low_at_done", 32'(busy_o), 32'd0);
      end
    end
  end

  initial begin
    cmd_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      cmd_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_seq(input logic [31:0] base, input int m, input int n, input int p,
                           input int q, input int w, input int xs);
    @(posedge clk_i);
    #1;
    base_i = base; m_i = 16'(m); n_i = 16'(n); p_i = 16'(p); q_i = 16'(q);
    w_i = 16'(w); xs_i = 5'(xs);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic run_seq(input logic [31:0] base, input int m, input int n, input int p,
                         input int q, input int w, input int xs, input int exp_n);
    int cyc;
    exp_q.delete();
    cap.delete();
    done_cnt = 0;
    gen_expected(base, m, n, p, q, w, xs);
    start_seq(base, m, n, p, q, w, xs);
    @(negedge clk_i);
    check("busy_after_start", 32'(busy_o), 32'd1);
    for (cyc = 0; cyc < 4000 && done_cnt == 0; cyc++) @(posedge clk_i);
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: actual no done after %0d cycles, required done", cyc);
    end
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("done_pulse_count", 32'(done_cnt), 32'd1);
    check("cmd_count", 32'(cap.size()), 32'(exp_n));
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("busy_idle_after", 32'(busy_o), 32'd0);
  endtask

  task automatic spot(input string name, input int idx, input logic [1:0] t,
                      input logic [31:0] a, input int r, input logic [31:0] imm);
    if (idx >= cap.size()) begin
      checks++;
      errors++;
      $display("FAIL %s[%0d]: actual missing, required type=%0d addr=%h", name, idx, t, a);
    end else begin
      check($sformatf("%s[%0d].type", name, idx), 32'(cap[idx].t), 32'(t));
      check($sformatf("%s[%0d].reg", name, idx), 32'(cap[idx].r), 32'(r));
      if (t == T_IMM) check($sformatf("%s[%0d].imm", name, idx), cap[idx].imm, imm);
      else            check($sformatf("%s[%0d].addr", name, idx), cap[idx].a, a);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(cmd_valid_o), 32'd0);
    check({tag, "_type"}, 32'(cmd_type_o), 32'd0);
    check({tag, "_addr"}, cmd_addr_o, 32'd0);
    check({tag, "_reg"}, 32'(cmd_reg_o), 32'd0);
    check({tag, "_imm"}, cmd_imm_o, 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  initial begin
    int cyc, dups, colq;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_outputs_zero("reset");
    rst_ni = 1'b1;

    // Single band, all columns, ready always high
    run_seq(0, 4, 5, 0, 0, 8, 8, 36);
    for (int k = 0; k < 4; k++) spot("single_pl", k, T_MEM, 32'(k), 8 + k, 0);
    spot("single_pl", 4, T_IMM, 0, 12, 32'h3f800000);
    spot("single_hdr", 5, T_MEM, 4, 0, 0);
    spot("single_row1", 6, T_MEM, 5, 16, 0);
    spot("single_row1", 7, T_MEM, 6, 17, 0);
    spot("single_row1", 8, T_STORE, 5, 16, 0);
    spot("single_row1", 9, T_MEM, 7, 16, 0);
    spot("single_ps", 32, T_STORE, 1, 9, 0);
    spot("single_ps", 33, T_STORE, 2, 10, 0);
    spot("single_ps", 34, T_STORE, 3, 11, 0);
    spot("single_ps", 35, T_STORE, 0, 12, 0);

    // Narrow bands: w=2 gives bands {0,1},{2,3},{4}
    run_seq(0, 4, 5, 0, 0, 2, 8, 42);
    spot("narrow_pl", 0, T_MEM, 0, 8, 0);
    spot("narrow_pl", 1, T_MEM, 1, 9, 0);
    spot("narrow_pl", 12, T_MEM, 2, 8, 0);
    spot("narrow_pl", 31, T_IMM, 0, 8, 32'h3f800000);
    dups = 0;
    for (int a = 0; a < cap.size(); a++)
      for (int b = a + 1; b < cap.size(); b++)
        if (cap[a].t == T_STORE && cap[b].t == T_STORE && cap[a].a == cap[b].a) dups++;
    check("narrow_store_addr_unique", 32'(dups), 32'd0);

    // Backpressure: same command stream with random stalls
    bp_en = 1'b1;
    run_seq(0, 4, 5, 0, 0, 8, 8, 36);
    bp_en = 1'b0;

    // Pivot column in the middle of the band
    run_seq(0, 4, 5, 2, 3, 8, 8, 36);
    colq = 0;
    foreach (cap[k]) if (cap[k].t == T_MEM && cap[k].r >= 5'd16 && cap[k].a[1:0] == 2'd3) colq++;
    check("midq_no_colq_elem", 32'(colq), 32'd0);
    spot("midq_ps", 32, T_STORE, 8, 8, 0);
    spot("midq_ps", 33, T_STORE, 9, 9, 0);
    spot("midq_ps", 34, T_STORE, 10, 10, 0);
    spot("midq_ps", 35, T_STORE, 11, 12, 0);

    // Invalid start (q = n-1) then an immediate valid start
    exp_q.delete();
    start_seq(0, 4, 5, 0, 4, 8, 8);
    @(negedge clk_i);
    check("bad_start_err", 32'(err_o), 32'd1);
    check("bad_start_busy", 32'(busy_o), 32'd0);
    check("bad_start_valid", 32'(cmd_valid_o), 32'd0);
    @(negedge clk_i);
    check("bad_start_err_one_cycle", 32'(err_o), 32'd0);
    check("bad_start_busy_later", 32'(busy_o), 32'd0);
    run_seq(0, 4, 5, 0, 0, 8, 8, 36);

    // Reset in the middle of a sequence, then a clean restart
    exp_q.delete();
    cap.delete();
    done_cnt = 0;
    gen_expected(0, 4, 5, 0, 0, 8, 8);
    start_seq(0, 4, 5, 0, 0, 8, 8);
    for (cyc = 0; cyc < 200 && cap.size() < 10; cyc++) @(posedge clk_i);
    check("midrst_transfers_seen", 32'(cap.size() >= 10), 32'd1);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    rst_ni = 1'b1;
    run_seq(0, 4, 5, 0, 0, 8, 8, 36);
    spot("restart", 0, T_MEM, 0, 8, 0);
    spot("restart", 35, T_STORE, 0, 12, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
